// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues synchronous imem reads and feeds IF/ID.
// A 2-entry skid buffer absorbs the read in flight when IF/ID stalls.
module fetch_unit #(
    parameter int                   PC_W      = 8,
    parameter int                   INSTR_W   = 20,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stall_in,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    inflight_pc;
    logic               inflight;
    logic [1:0]         count;
    logic               head;
    logic [PC_W-1:0]    buf_pc    [2];
    logic [INSTR_W-1:0] buf_instr [2];

    logic               pop;
    logic               push;
    logic               tail;
    logic [2:0]         occ;

    assign pop  = !stall_in && (count != 2'd0);
    assign push = inflight && !redirect_valid;
    assign tail = head ^ count[0];

    // Occupancy after this edge if a new request were not issued.
    assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    assign imem_req  = rstn && !redirect_valid && (occ < 3'd2);
    assign imem_addr = fetch_pc;

    assign if_valid = (count != 2'd0);
    assign if_pc    = if_valid ? buf_pc[head] : '0;
    assign if_instr = if_valid ? buf_instr[head] : NOP_INSTR;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            head        <= 1'b0;
            buf_pc      <= '{default: '0};
            buf_instr   <= '{default: '0};
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            count    <= 2'd0;
            head     <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + PC_W'(1);
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                buf_pc[tail]    <= inflight_pc;
                buf_instr[tail] <= imem_rdata;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect,
// checked every cycle against a queue-based model of the fetch stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [19:0] imem_rdata = 20'h0;
    logic        if_valid;
    logic [7:0]  if_pc;
    logic [19:0] if_instr;

    fetch_unit #(
        .PC_W(8), .INSTR_W(20), .RESET_PC(8'h00), .NOP_INSTR(20'h0)
    ) dut (
        .clk(clk), .rstn(rstn), .stall_in(stall_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [19:0] instr;
    } ent_t;

    logic [19:0] mem [256];
    ent_t        fifo [$];
    logic [7:0]  pend [$];
    logic [7:0]  m_pc = 8'h00;
    logic        rst_drive = 1'b0;
    int          total = 0;
    int          bad = 0;

    // Synchronous instruction memory; junk on the bus when not requested.
    always @(posedge clk)
        imem_rdata <= imem_req ? mem[imem_addr] : 20'($urandom);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        pend.delete();
        m_pc = 8'h00;
    endtask

    function automatic logic exp_pop();
        return !stall_in && fifo.size() > 0;
    endfunction

    function automatic logic exp_req();
        int occ;
        occ = fifo.size() + pend.size() - (exp_pop() ? 1 : 0);
        return rstn && !redirect_valid && occ < 2;
    endfunction

    task automatic check_outputs();
        logic       v;
        logic [7:0] hp;
        logic [19:0] hi;
        v  = fifo.size() > 0;
        hp = v ? fifo[0].pc : 8'h00;
        hi = v ? fifo[0].instr : 20'h0;
        chk("imem_req", 32'(imem_req), 32'(exp_req()));
        if (exp_req())
            chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("if_valid", 32'(if_valid), 32'(v));
        chk("if_pc", 32'(if_pc), 32'(hp));
        chk("if_instr", 32'(if_instr), 32'(hi));
        chk("count", 32'(dut.count), 32'(fifo.size()));
        chk("no_overflow", 32'(dut.count == 2'd2 && dut.inflight), 32'(0));
    endtask

    task automatic model_edge();
        logic p;
        logic r;
        ent_t e;
        if (!rstn) begin
            model_reset();
            return;
        end
        p = exp_pop();
        r = exp_req();
        if (redirect_valid) begin
            fifo.delete();
            pend.delete();
            m_pc = redirect_pc;
            return;
        end
        if (p)
            void'(fifo.pop_front());
        if (pend.size() > 0) begin
            e.pc    = pend.pop_front();
            e.instr = mem[e.pc];
            fifo.push_back(e);
        end
        if (r) begin
            pend.push_back(m_pc);
            m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic step(input logic st, input logic rv, input logic [7:0] rp);
        @(negedge clk);
        rstn           = rst_drive;
        stall_in       = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        check_outputs();
        model_edge();
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(9) < 3, $urandom_range(11) == 0,
                 8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 20'(i + 'h100);

        rst_drive = 1'b0;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        rst_drive = 1'b1;
        repeat (4) step(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            if (fifo.size() > 0 && fifo[0].pc == 8'h05)
                break;
            step(1'b0, 1'b0, 8'h00);
        end
        repeat (3) step(1'b1, 1'b0, 8'h00);
        repeat (6) step(1'b0, 1'b0, 8'h00);

        repeat (2) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h40);
        repeat (5) step(1'b0, 1'b0, 8'h00);

        step(1'b1, 1'b1, 8'h40);
        repeat (4) step(1'b1, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        step(1'b0, 1'b1, 8'hFE);
        repeat (8) step(1'b0, 1'b0, 8'h00);

        rand_steps(300);

        step(1'b0, 1'b1, 8'h80);
        repeat (4) step(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        stall_in       = 1'b1;
        redirect_valid = 1'b0;
        #2;
        rst_drive = 1'b0;
        rstn      = 1'b0;
        #1;
        model_reset();
        check_outputs();
        for (int i = 0; i < 256; i++)
            mem[i] = 20'($urandom);
        repeat (2) step(1'b1, 1'b0, 8'h00);
        rst_drive = 1'b1;
        repeat (6) step(1'b0, 1'b0, 8'h00);

        rand_steps(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
